register_controller: RTL and testbench

REGISTER_CONTROLLER -- requirements
Module: register_controller

---
 rtl/register_controller.sv | 145 ++++++++++++++
 tb/tb_register_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_controller.sv
// Sequencer for an external shift register: clear, transmit LSB-first,
// or receive serially, with abort and synchronous reset.
module register_controller #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   input  logic [WIDTH-1:0] reg_data,
   output logic [2:0]       ctrl,
   output logic [WIDTH-1:0] par_data,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             done,
   output logic [WIDTH-1:0] rx_data
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_CLR  = 3'd1;
   localparam logic [2:0] C_PLD  = 3'd2;
   localparam logic [2:0] C_SML  = 3'd3;
   localparam logic [2:0] C_SLR  = 3'd6;

   localparam logic [1:0] OP_CLEAR = 2'd0;
   localparam logic [1:0] OP_TX    = 2'd1;
   localparam logic [1:0] OP_RX    = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_SHIFT,
      S_RECV,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] par_q, par_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             ready_q, ready_d;
   logic             txv_q, txv_d;
   logic             done_q, done_d;
   logic             last;

   assign last = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               unique case (cmd_op)
                  OP_CLEAR: state_d = S_CLEAR;
                  OP_TX: begin
                     state_d = S_LOAD;
                     par_d   = cmd_data;
                  end
                  OP_RX: begin
                     state_d = S_RECV;
                     cnt_d   = '0;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_CLEAR: state_d = S_DONE;
         S_LOAD: begin
            if (abort) begin
               state_d = S_CLEAR;
            end else begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end
         end
         S_SHIFT, S_RECV: begin
            if (abort) begin
               state_d = S_CLEAR;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (last) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register with it.
   always_comb begin
      ctrl_d  = C_NONE;
      ready_d = 1'b0;
      txv_d   = 1'b0;
      done_d  = 1'b0;
      unique case (state_d)
         S_IDLE:  ready_d = 1'b1;
         S_CLEAR: ctrl_d  = C_CLR;
         S_LOAD:  ctrl_d  = C_PLD;
         S_SHIFT: begin
            ctrl_d = C_SLR;
            txv_d  = 1'b1;
         end
         S_RECV:  ctrl_d = C_SML;
         S_DONE:  done_d = 1'b1;
         default: ctrl_d = C_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         par_q   <= '0;
         ctrl_q  <= C_NONE;
         ready_q <= 1'b1;
         txv_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         ctrl_q  <= ctrl_d;
         ready_q <= ready_d;
         txv_q   <= txv_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = ready_q;
   assign ctrl      = ctrl_q;
   assign par_data  = par_q;
   assign tx_valid  = txv_q;
   assign done      = done_q;
   assign tx_bit    = reg_data[0];
   assign rx_data   = reg_data;

endmodule

// File: tb/tb_register_controller.sv
// Scoreboard bench: commands push expected ctrl/tx/done events,
// a negedge monitor pops and compares them against the DUT.
module tb_register_controller;

   localparam int W = 8;

   localparam int P_PL   = 0;
   localparam int P_SR   = 1;
   localparam int P_SML  = 2;
   localparam int P_CLR  = 3;
   localparam int P_DONE = 4;

   logic         clk = 1'b0;
   logic         sync_reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic         abort;
   logic [W-1:0] reg_data;
   logic [2:0]   ctrl;
   logic [W-1:0] par_data;
   logic         tx_bit;
   logic         tx_valid;
   logic         done;
   logic [W-1:0] rx_data;

   register_controller #(.WIDTH(W)) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .abort      (abort),
      .reg_data   (reg_data),
      .ctrl       (ctrl),
      .par_data   (par_data),
      .tx_bit     (tx_bit),
      .tx_valid   (tx_valid),
      .done       (done),
      .rx_data    (rx_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   ev_t exp_ctrl[$];
   ev_t exp_tx[$];
   ev_t exp_done[$];
   bit  ser_q[$];

   int cyc = 0;
   int exp_free = 0;
   int n_vec = 0;
   int n_bad = 0;
   bit mon_en = 0;

   logic [W-1:0] rq = '0;
   bit sb;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model of the controlled shift register.
   always @(posedge clk) begin
      case (ctrl)
         3'd1: rq <= '0;
         3'd2: rq <= par_data;
         3'd3: begin
            sb = (ser_q.size() > 0) ? ser_q.pop_front() : 1'b0;
            rq <= {sb, rq[W-1:1]};
         end
         3'd6: rq <= rq >> 1;
         default: ;
      endcase
   end

   assign reg_data = rq;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         chk("rx_passthru", rx_data, rq);
         chk("tx_bit_passthru", tx_bit, rq[0]);
         if (ctrl !== 3'd0) begin
            if (exp_ctrl.size() == 0) begin
               chk("ctrl_unexpected", ctrl, 0);
            end else begin
               e = exp_ctrl.pop_front();
               chk("ctrl_val", ctrl, e.val);
               chk("ctrl_cycle", cyc, e.cyc);
            end
         end
         if (tx_valid !== 1'b0) begin
            if (exp_tx.size() == 0) begin
               chk("tx_valid_unexpected", tx_valid, 0);
            end else begin
               e = exp_tx.pop_front();
               chk("tx_bit", tx_bit, e.val);
               chk("tx_cycle", cyc, e.cyc);
            end
         end
         if (done !== 1'b0) begin
            if (exp_done.size() == 0) begin
               chk("done_unexpected", done, 0);
            end else begin
               e = exp_done.pop_front();
               chk("done_rx_data", rx_data, e.val);
               chk("done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // kind: 0 normal, 1 abort in cycle j, 2 reset in cycle j.
   // Called and returns just after a falling edge.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                        input int kind, input int j, input bit hold);
      int a;
      int sh;
      int guard;
      int ph[$];
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      guard     = 0;
      while (1) begin
         chk("cmd_ready", cmd_ready, (cyc >= exp_free));
         if (cmd_ready === 1'b1) break;
         guard++;
         if (guard > 100) begin
            chk("accept_timeout", guard, 0);
            cmd_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      a = cyc + 1;
      case (op)
         2'd0: ph = '{P_CLR, P_DONE};
         2'd1: begin
            ph.push_back(P_PL);
            for (int i = 0; i < W; i++) ph.push_back(P_SR);
            ph.push_back(P_DONE);
         end
         2'd2: begin
            for (int i = 0; i < W; i++) ph.push_back(P_SML);
            ph.push_back(P_DONE);
            for (int i = 0; i < W; i++) ser_q.push_back(data[i]);
         end
         default: ;
      endcase
      if (kind != 0) begin
         while (ph.size() > j) void'(ph.pop_back());
         if (kind == 1) begin
            ph.push_back(P_CLR);
            ph.push_back(P_DONE);
         end
      end
      sh = 0;
      for (int c = 0; c < ph.size(); c++) begin
         case (ph[c])
            P_PL:  exp_ctrl.push_back('{a + c, 2});
            P_SML: exp_ctrl.push_back('{a + c, 3});
            P_CLR: exp_ctrl.push_back('{a + c, 1});
            P_SR: begin
               exp_ctrl.push_back('{a + c, 6});
               exp_tx.push_back('{a + c, int'(data[sh])});
               sh++;
            end
            default: exp_done.push_back('{a + c,
               (op == 2'd2 && kind == 0) ? int'(data) : 0});
         endcase
      end
      exp_free = a + ph.size();
      @(posedge clk);
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      if (kind != 0) begin
         repeat (j - 1) @(negedge clk);
         if (kind == 1) abort = 1'b1;
         else sync_reset = 1'b1;
         @(negedge clk);
         abort      = 1'b0;
         sync_reset = 1'b0;
         ser_q.delete();
         if (kind == 2) begin
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_ctrl", ctrl, 0);
            chk("rst_par_data", par_data, 0);
         end
         cmd_valid = 1'b0;
      end
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] d;
      int           kind;
      int           j;
      int           r;
      bit           hold;
      sync_reset = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'd0;
      cmd_data   = '0;
      abort      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", ctrl, 0);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_tx_valid", tx_valid, 0);
      chk("reset_done", done, 0);
      chk("reset_par_data", par_data, 0);
      sync_reset = 1'b0;
      exp_free   = cyc;
      mon_en     = 1'b1;

      issue(2'd1, 8'hF0, 0, 0, 0);
      repeat (2) @(negedge clk);
      issue(2'd2, 8'b0100_1101, 0, 0, 0);
      issue(2'd2, 8'hA5, 0, 0, 0);
      issue(2'd0, 8'h00, 0, 0, 0);
      issue(2'd1, 8'h3C, 1, 4, 0);
      issue(2'd2, 8'h96, 2, 4, 0);
      @(negedge clk);
      issue(2'd1, 8'h5A, 0, 0, 1);
      issue(2'd2, 8'hC3, 0, 0, 1);
      issue(2'd0, 8'hFF, 0, 0, 1);
      issue(2'd3, 8'h77, 0, 0, 0);
      issue(2'd0, 8'h11, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         op   = 2'($urandom_range(0, 3));
         d    = W'($urandom);
         r    = $urandom_range(0, 9);
         kind = 0;
         if (op == 2'd1 || op == 2'd2)
            kind = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
         j    = (op == 2'd1) ? $urandom_range(1, W + 1)
                             : $urandom_range(1, W);
         hold = 1'($urandom_range(0, 1));
         issue(op, d, kind, j, hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      cmd_valid = 1'b0;
      while (cyc < exp_free + 2) @(negedge clk);
      chk("ctrl_events_left", exp_ctrl.size(), 0);
      chk("tx_events_left", exp_tx.size(), 0);
      chk("done_events_left", exp_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
